// File: rtl/alu_iter_if.sv
// Request/response bundle for alu_iter: operands and op code in, results and flags out.
// master drives requests (EX stage / bench), slave is the ALU.
interface alu_iter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) ();
    logic             start_i;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [SHW-1:0]   shamt_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] result_hi_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;
    logic             div_zero_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, shamt_i,
        input  busy_o, done_o, result_o, result_hi_o, zero_o, cout_o, overflow_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, shamt_i,
        output busy_o, done_o, result_o, result_hi_o, zero_o, cout_o, overflow_o, div_zero_o
    );
endinterface

// File: rtl/alu_iter.sv
// Clocked ALU: single-cycle logic/arith/shift/compare ops plus iterative shift-add MUL
// and restoring DIVU, all behind one start/done handshake.
module alu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_iter_if.slave  bus
);
    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpMul  = 4'b0011;
    localparam logic [3:0] OpSra  = 4'b0100;
    localparam logic [3:0] OpDivu = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSll  = 4'b1000;
    localparam logic [3:0] OpSrl  = 4'b1001;
    localparam logic [3:0] OpSllv = 4'b1010;
    localparam logic [3:0] OpSrlv = 4'b1011;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpSltu = 4'b1101;
    localparam logic [3:0] OpXor  = 4'b1110;

    localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StOne, StMul, StDiv} state_e;

    state_e             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   a_q, a_d;        // multiplicand or divisor
    logic [2*WIDTH-1:0] p_q, p_d;        // {hi, lo} product or {remainder, quotient}
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               zero_q, zero_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               dz_q, dz_d;

    logic [WIDTH-1:0] src1, src2, src2_inv;
    logic [WIDTH:0]   add_sum, sub_sum;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_cout, sc_ovf, sc_dz, sc_legal, sc_zero;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign src1     = bus.src1_i;
    assign src2     = bus.src2_i;
    assign src2_inv = ~bus.src2_i;

    // Single-cycle results straight from the request inputs, latched on acceptance.
    always_comb begin
        sc_res   = '0;
        sc_hi    = '0;
        sc_cout  = 1'b0;
        sc_ovf   = 1'b0;
        sc_dz    = 1'b0;
        sc_legal = 1'b1;
        add_sum  = {1'b0, src1} + {1'b0, src2};
        sub_sum  = {1'b0, src1} + {1'b0, src2_inv} + {{WIDTH{1'b0}}, 1'b1};
        case (bus.op_i)
            OpAnd:  sc_res = src1 & src2;
            OpOr:   sc_res = src1 | src2;
            OpNor:  sc_res = ~(src1 | src2);
            OpXor:  sc_res = src1 ^ src2;
            OpAdd: begin
                sc_res  = add_sum[WIDTH-1:0];
                sc_cout = add_sum[WIDTH];
                sc_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OpSub: begin
                sc_res  = sub_sum[WIDTH-1:0];
                sc_cout = sub_sum[WIDTH];
                sc_ovf  = (src1[WIDTH-1] == src2_inv[WIDTH-1]) &&
                          (sub_sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OpSlt:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            OpSltu: sc_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
            OpSll:  sc_res = src2 << bus.shamt_i;
            OpSrl:  sc_res = src2 >> bus.shamt_i;
            OpSra:  sc_res = $unsigned($signed(src2) >>> bus.shamt_i);
            OpSllv: sc_res = src2 << src1[SHW-1:0];
            OpSrlv: sc_res = src2 >> src1[SHW-1:0];
            OpDivu: begin
                // Only reached with a zero divisor; nonzero divisors go to StDiv.
                sc_res = '1;
                sc_hi  = src1;
                sc_dz  = 1'b1;
            end
            default: sc_legal = 1'b0;
        endcase
        sc_zero = sc_legal && (sc_res == '0);
    end

    // One iteration step of each multi-cycle unit.
    always_comb begin
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, p_q[WIDTH-1:1]};
        div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, a_q};
        div_ok    = ~div_diff[WIDTH];
        div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_next  = {div_rem, p_q[WIDTH-2:0], div_ok};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        a_d         = a_q;
        p_d         = p_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    cnt_d = '0;
                    if (bus.op_i == OpMul) begin
                        a_d     = src1;
                        p_d     = {{WIDTH{1'b0}}, src2};
                        state_d = StMul;
                    end else if (bus.op_i == OpDivu && src2 != '0) begin
                        a_d     = src2;
                        p_d     = {{WIDTH{1'b0}}, src1};
                        state_d = StDiv;
                    end else begin
                        result_d    = sc_res;
                        result_hi_d = sc_hi;
                        zero_d      = sc_zero;
                        cout_d      = sc_cout;
                        ovf_d       = sc_ovf;
                        dz_d        = sc_dz;
                        done_d      = 1'b1;
                        state_d     = StOne;
                    end
                end
            end
            StOne: state_d = StIdle;
            StMul: begin
                if (done_q) begin
                    state_d = StIdle;
                end else begin
                    p_d   = mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        cnt_d       = '0;
                        done_d      = 1'b1;
                        result_d    = mul_next[WIDTH-1:0];
                        result_hi_d = mul_next[2*WIDTH-1:WIDTH];
                        zero_d      = (mul_next[WIDTH-1:0] == '0);
                        cout_d      = 1'b0;
                        ovf_d       = (mul_next[2*WIDTH-1:WIDTH] != '0);
                        dz_d        = 1'b0;
                    end
                end
            end
            StDiv: begin
                if (done_q) begin
                    state_d = StIdle;
                end else begin
                    p_d   = div_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        cnt_d       = '0;
                        done_d      = 1'b1;
                        result_d    = div_next[WIDTH-1:0];
                        result_hi_d = div_next[2*WIDTH-1:WIDTH];
                        zero_d      = (div_next[WIDTH-1:0] == '0);
                        cout_d      = 1'b0;
                        ovf_d       = 1'b0;
                        dz_d        = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            a_q         <= '0;
            p_q         <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            a_q         <= a_d;
            p_q         <= p_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
        end
    end

    assign bus.busy_o      = (state_q != StIdle);
    assign bus.done_o      = done_q;
    assign bus.result_o    = result_q;
    assign bus.result_hi_o = result_hi_q;
    assign bus.zero_o      = zero_q;
    assign bus.cout_o      = cout_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.div_zero_o  = dz_q;
endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: hand-computed vectors for every op, latency, busy/done
// handshake, operand capture and reset behaviour.
module tb_alu_iter;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    alu_iter_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    alu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  sh;
        logic [31:0] res;
        logic [3:0]  flags;  // {zero, cout, overflow, div_zero}
    } vec_t;

    vec_t vecs [15];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.zero_o, bus.cout_o, bus.overflow_o, bus.div_zero_o};
    endfunction

    // Issue one op and wait (bounded) for done; hold keeps start high and scrambles inputs.
    task automatic run_op(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [4:0] sh, input bit hold, output int lat);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = s1;
        bus.src2_i  = s2;
        bus.shamt_i = sh;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (!hold || bus.done_o) begin
                bus.start_i = 1'b0;
            end else begin
                bus.op_i   = 4'b0010;
                bus.src1_i = 32'h0000_0001;
                bus.src2_i = 32'h0000_0002;
            end
            if (bus.done_o) break;
        end
        bus.start_i = 1'b0;
    endtask

    initial begin
        int lat;
        int dones;
        n_cmp = 0;
        n_err = 0;
        vecs[0]  = '{4'b0100, 32'h0,        32'h8000_0000, 5'd4,  32'hF800_0000, 4'b0000};
        vecs[1]  = '{4'b1010, 32'h23,       32'h1,         5'd7,  32'h8,         4'b0000};
        vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h1,        5'd0,  32'h1,         4'b0000};
        vecs[3]  = '{4'b1101, 32'hFFFF_FFFF, 32'h1,        5'd0,  32'h0,         4'b1000};
        vecs[4]  = '{4'b0111, 32'h1,        32'hFFFF_FFFF, 5'd0,  32'h0,         4'b1000};
        vecs[5]  = '{4'b1101, 32'h1,        32'hFFFF_FFFF, 5'd0,  32'h1,         4'b0000};
        vecs[6]  = '{4'b0000, 32'hF0F0,     32'hFF00,      5'd0,  32'hF000,      4'b0000};
        vecs[7]  = '{4'b0001, 32'hF0F0,     32'hFF00,      5'd0,  32'hFFF0,      4'b0000};
        vecs[8]  = '{4'b1100, 32'hF0F0,     32'hFF00,      5'd0,  32'hFFFF_000F, 4'b0000};
        vecs[9]  = '{4'b1000, 32'h0,        32'h1,         5'd31, 32'h8000_0000, 4'b0000};
        vecs[10] = '{4'b1001, 32'h0,        32'h8000_0000, 5'd31, 32'h1,         4'b0000};
        vecs[11] = '{4'b1011, 32'h4,        32'h100,       5'd9,  32'h10,        4'b0000};
        vecs[12] = '{4'b0110, 32'h8000_0000, 32'h1,        5'd0,  32'h7FFF_FFFF, 4'b0110};
        vecs[13] = '{4'b1110, 32'hF0F0,     32'hFF00,      5'd0,  32'h0FF0,      4'b0000};
        vecs[14] = '{4'b1111, 32'hFFFF,     32'h1234,      5'd3,  32'h0,         4'b0000};

        bus.start_i = 1'b0;
        bus.op_i    = '0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.shamt_i = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_outputs", {bus.busy_o, bus.done_o, bus.result_o, bus.result_hi_o,
                                      flags()}, '0);
        end

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0, lat);
        check_eq("add_lat", lat, 1);
        check_eq("add_busy", bus.busy_o, 1'b1);
        check_eq("add_res", bus.result_o, 32'h8000_0000);
        check_eq("add_flags", flags(), 4'b0010);

        run_op(4'b0110, 32'h5, 32'h5, 5'd0, 1'b0, lat);
        check_eq("sub_lat", lat, 1);
        check_eq("sub_res", bus.result_o, 32'h0);
        check_eq("sub_flags", flags(), 4'b1100);

        run_op(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1, lat);
        check_eq("mul_lat", lat, 33);
        check_eq("mul_lo", bus.result_o, 32'h0000_0001);
        check_eq("mul_hi", bus.result_hi_o, 32'hFFFF_FFFE);
        check_eq("mul_flags", flags(), 4'b0010);
        @(negedge clk);
        check_eq("mul_busy_after", {bus.busy_o, bus.done_o}, 2'b00);

        run_op(4'b0011, 32'h1234_5678, 32'h10, 5'd0, 1'b0, lat);
        check_eq("mul2_prod", {bus.result_hi_o, bus.result_o}, 64'h1_2345_6780);
        check_eq("mul2_flags", flags(), 4'b0010);

        run_op(4'b0011, 32'h3, 32'h5, 5'd0, 1'b0, lat);
        check_eq("mul3_prod", {bus.result_hi_o, bus.result_o}, 64'hF);
        check_eq("mul3_flags", flags(), 4'b0000);

        run_op(4'b0101, 32'd100, 32'd7, 5'd0, 1'b0, lat);
        check_eq("div_lat", lat, 33);
        check_eq("div_quo", bus.result_o, 32'd14);
        check_eq("div_rem", bus.result_hi_o, 32'd2);
        check_eq("div_flags", flags(), 4'b0000);
        repeat (3) @(negedge clk);
        check_eq("div_hold", {bus.result_hi_o, bus.result_o}, {32'd2, 32'd14});

        run_op(4'b0101, 32'd7, 32'd100, 5'd0, 1'b0, lat);
        check_eq("div2_qr", {bus.result_hi_o, bus.result_o}, {32'd7, 32'd0});
        check_eq("div2_flags", flags(), 4'b1000);

        run_op(4'b0101, 32'd9, 32'd0, 5'd0, 1'b0, lat);
        check_eq("div0_lat", lat, 1);
        check_eq("div0_quo", bus.result_o, 32'hFFFF_FFFF);
        check_eq("div0_rem", bus.result_hi_o, 32'd9);
        check_eq("div0_flags", flags(), 4'b0001);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].sh, 1'b0, lat);
            check_eq($sformatf("vec%0d_lat", i), lat, 1);
            check_eq($sformatf("vec%0d_res", i), {bus.result_hi_o, bus.result_o},
                     {32'h0, vecs[i].res});
            check_eq($sformatf("vec%0d_flags", i), flags(), vecs[i].flags);
        end

        // Load nonzero outputs, then abort a MUL at iteration 10.
        run_op(4'b0010, 32'h10, 32'h20, 5'd0, 1'b0, lat);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 4'b0011;
        bus.src1_i  = 32'hFFFF_FFFF;
        bus.src2_i  = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_state", {bus.busy_o, bus.done_o, bus.result_o, bus.result_hi_o,
                                 flags()}, '0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) dones++;
        end
        check_eq("abort_no_done", dones, 0);

        run_op(4'b0010, 32'd2, 32'd3, 5'd0, 1'b0, lat);
        check_eq("post_rst_add", bus.result_o, 32'd5);
        check_eq("post_rst_lat", lat, 1);

        // Reset and start together: request dropped.
        @(negedge clk);
        rst         = 1'b1;
        bus.start_i = 1'b1;
        bus.op_i    = 4'b0010;
        bus.src1_i  = 32'd2;
        bus.src2_i  = 32'd3;
        @(negedge clk);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        check_eq("rst_start_busy", {bus.busy_o, bus.done_o}, 2'b00);
        @(negedge clk);
        check_eq("rst_start_out", {bus.busy_o, bus.done_o, bus.result_o}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
